// File: rtl/sd_wb_cmd_master_if.sv
// Wishbone single-transfer bus between the SD command master and the SD host controller.
interface sd_wb_cmd_master_if;
    logic [7:0]  wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/sd_wb_cmd_master.sv
// Sequences SD host controller register accesses for a command (write, poll, read back, clear
// ISRs) or a buffer-descriptor push, reporting the outcome as a one-cycle response.
module sd_wb_cmd_master #(
    parameter logic [15:0] POLL_MAX = 16'd1000,
    parameter logic [7:0]  POLL_GAP = 8'd4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         req_kind_i,
    input  logic [15:0]        req_cmd_i,
    input  logic [31:0]        req_arg_i,
    input  logic [31:0]        req_arg2_i,
    sd_wb_cmd_master_if.master wbm,
    output logic               rsp_valid_o,
    output logic [31:0]        rsp_resp_o,
    output logic [15:0]        rsp_nisr_o,
    output logic [15:0]        rsp_eisr_o,
    output logic               rsp_timeout_o
);

    localparam logic [7:0] AdrArg    = 8'h00;
    localparam logic [7:0] AdrCmd    = 8'h04;
    localparam logic [7:0] AdrStatus = 8'h08;
    localparam logic [7:0] AdrResp1  = 8'h0C;
    localparam logic [7:0] AdrNisr   = 8'h30;
    localparam logic [7:0] AdrEisr   = 8'h34;
    localparam logic [7:0] AdrBdRx   = 8'h60;
    localparam logic [7:0] AdrBdTx   = 8'h80;

    typedef enum logic [3:0] {
        StIdle, StWrCmd, StWrArg, StPollRd, StPollWait, StRdResp, StRdNisr,
        StRdEisr, StClrNisr, StClrEisr, StBdW0, StBdW1, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  kind_q, kind_d;
    logic [15:0] cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d, arg2_q, arg2_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic [31:0] resp_q, resp_d;
    logic [15:0] nisr_q, nisr_d, eisr_q, eisr_d;
    logic        tmo_q, tmo_d;
    logic [31:0] rsp_resp_q;
    logic [15:0] rsp_nisr_q, rsp_eisr_q;
    logic        rsp_tmo_q;
    logic        cyc_q, cyc_d, we_q, we_d;
    logic [7:0]  adr_q, adr_d;
    logic [31:0] dat_q, dat_d;

    logic        acc_en, acc_we;
    logic [7:0]  acc_adr;
    logic [31:0] acc_dat;
    logic        accept, bus_ack;
    logic [15:0] poll_cnt_inc;
    logic [7:0]  bd_adr;

    assign req_ready_o  = (state_q == StIdle);
    assign accept       = req_valid_i & req_ready_o;
    assign bus_ack      = cyc_q & wbm.wbm_ack_i;
    assign poll_cnt_inc = poll_cnt_q + 16'd1;
    assign bd_adr       = (kind_q == 2'd1) ? AdrBdTx : AdrBdRx;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        arg2_d     = arg2_q;
        poll_cnt_d = poll_cnt_q;
        gap_d      = gap_q;
        resp_d     = resp_q;
        nisr_d     = nisr_q;
        eisr_d     = eisr_q;
        tmo_d      = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    kind_d     = req_kind_i;
                    cmd_d      = req_cmd_i;
                    arg_d      = req_arg_i;
                    arg2_d     = req_arg2_i;
                    poll_cnt_d = 16'd0;
                    gap_d      = 8'd0;
                    resp_d     = 32'd0;
                    nisr_d     = 16'd0;
                    eisr_d     = 16'd0;
                    tmo_d      = 1'b0;
                    state_d    = (req_kind_i == 2'd1 || req_kind_i == 2'd2) ? StBdW0 : StWrCmd;
                end
            end
            StWrCmd: if (bus_ack) state_d = StWrArg;
            StWrArg: if (bus_ack) state_d = StPollRd;
            StPollRd: begin
                if (bus_ack) begin
                    poll_cnt_d = poll_cnt_inc;
                    if (!wbm.wbm_dat_i[0]) begin
                        state_d = StRdResp;
                    end else if (poll_cnt_inc >= POLL_MAX) begin
                        tmo_d   = 1'b1;
                        state_d = StRdNisr;
                    end else if (POLL_GAP == 8'd0) begin
                        // Re-issuing from StPollRd already yields the mandatory idle cycle.
                        state_d = StPollRd;
                    end else begin
                        gap_d   = POLL_GAP - 8'd1;
                        state_d = StPollWait;
                    end
                end
            end
            StPollWait: begin
                if (gap_q == 8'd0) begin
                    state_d = StPollRd;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            StRdResp: begin
                if (bus_ack) begin
                    resp_d  = wbm.wbm_dat_i;
                    state_d = StRdNisr;
                end
            end
            StRdNisr: begin
                if (bus_ack) begin
                    nisr_d  = wbm.wbm_dat_i[15:0];
                    state_d = StRdEisr;
                end
            end
            StRdEisr: begin
                if (bus_ack) begin
                    eisr_d = wbm.wbm_dat_i[15:0];
                    if (nisr_q != 16'd0) begin
                        state_d = StClrNisr;
                    end else if (wbm.wbm_dat_i[15:0] != 16'd0) begin
                        state_d = StClrEisr;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StClrNisr: if (bus_ack) state_d = (eisr_q != 16'd0) ? StClrEisr : StDone;
            StClrEisr: if (bus_ack) state_d = StDone;
            StBdW0:    if (bus_ack) state_d = StBdW1;
            StBdW1:    if (bus_ack) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        acc_en  = 1'b1;
        acc_we  = 1'b0;
        acc_adr = 8'h00;
        acc_dat = 32'd0;
        unique case (state_q)
            StWrCmd: begin
                acc_we  = 1'b1;
                acc_adr = AdrCmd;
                acc_dat = {16'h0000, cmd_q};
            end
            StWrArg: begin
                acc_we  = 1'b1;
                acc_adr = AdrArg;
                acc_dat = arg_q;
            end
            StPollRd:  acc_adr = AdrStatus;
            StRdResp:  acc_adr = AdrResp1;
            StRdNisr:  acc_adr = AdrNisr;
            StRdEisr:  acc_adr = AdrEisr;
            StClrNisr: begin
                acc_we  = 1'b1;
                acc_adr = AdrNisr;
            end
            StClrEisr: begin
                acc_we  = 1'b1;
                acc_adr = AdrEisr;
            end
            StBdW0: begin
                acc_we  = 1'b1;
                acc_adr = bd_adr;
                acc_dat = arg_q;
            end
            StBdW1: begin
                acc_we  = 1'b1;
                acc_adr = bd_adr;
                acc_dat = arg2_q;
            end
            default: acc_en = 1'b0;
        endcase

        // Launch only from an idle bus; the ack cycle drops cyc so accesses are always separated.
        cyc_d = cyc_q;
        we_d  = we_q;
        adr_d = adr_q;
        dat_d = dat_q;
        if (cyc_q) begin
            if (wbm.wbm_ack_i) begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
            end
        end else if (acc_en) begin
            cyc_d = 1'b1;
            we_d  = acc_we;
            adr_d = acc_adr;
            dat_d = acc_dat;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            kind_q     <= 2'd0;
            cmd_q      <= 16'd0;
            arg_q      <= 32'd0;
            arg2_q     <= 32'd0;
            poll_cnt_q <= 16'd0;
            gap_q      <= 8'd0;
            resp_q     <= 32'd0;
            nisr_q     <= 16'd0;
            eisr_q     <= 16'd0;
            tmo_q      <= 1'b0;
            rsp_resp_q <= 32'd0;
            rsp_nisr_q <= 16'd0;
            rsp_eisr_q <= 16'd0;
            rsp_tmo_q  <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 8'h00;
            dat_q      <= 32'd0;
        end else begin
            kind_q     <= kind_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            arg2_q     <= arg2_d;
            poll_cnt_q <= poll_cnt_d;
            gap_q      <= gap_d;
            resp_q     <= resp_d;
            nisr_q     <= nisr_d;
            eisr_q     <= eisr_d;
            tmo_q      <= tmo_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            // Published on entry to StDone so the data is valid alongside rsp_valid_o.
            if (state_d == StDone) begin
                rsp_resp_q <= resp_d;
                rsp_nisr_q <= nisr_d;
                rsp_eisr_q <= eisr_d;
                rsp_tmo_q  <= tmo_d;
            end
        end
    end

    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign wbm.wbm_sel_o = 4'hF;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;

    assign rsp_valid_o   = (state_q == StDone);
    assign rsp_resp_o    = rsp_resp_q;
    assign rsp_nisr_o    = rsp_nisr_q;
    assign rsp_eisr_o    = rsp_eisr_q;
    assign rsp_timeout_o = rsp_tmo_q;

endmodule

// File: tb/tb_sd_wb_cmd_master.sv
// Bench for sd_wb_cmd_master: modelled Wishbone slave, bus protocol monitor, table and random
// requests compared against a transaction-list reference model.
module tb_sd_wb_cmd_master;

    localparam logic [15:0] PM = 16'd5;
    localparam logic [7:0]  PG = 8'd2;

    typedef struct packed {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
    } txn_t;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] cmd;
        logic [31:0] arg;
        logic [31:0] arg2;
        int          busy;
        int          delay;
        logic [31:0] resp;
        logic [15:0] nisr;
        logic [15:0] eisr;
        int          exp_n;
        logic [31:0] exp_resp;
        logic [15:0] exp_nisr;
        logic [15:0] exp_eisr;
        logic        exp_tmo;
        logic [7:0]  exp_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = 2'd0;
    logic [15:0] req_cmd = 16'd0;
    logic [31:0] req_arg = 32'd0;
    logic [31:0] req_arg2 = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_resp;
    logic [15:0] rsp_nisr;
    logic [15:0] rsp_eisr;
    logic        rsp_tmo;

    int chk = 0;
    int err = 0;

    sd_wb_cmd_master_if wb ();

    sd_wb_cmd_master #(.POLL_MAX(PM), .POLL_GAP(PG)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n_i   (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_kind_i   (req_kind),
        .req_cmd_i    (req_cmd),
        .req_arg_i    (req_arg),
        .req_arg2_i   (req_arg2),
        .wbm          (wb),
        .rsp_valid_o  (rsp_valid),
        .rsp_resp_o   (rsp_resp),
        .rsp_nisr_o   (rsp_nisr),
        .rsp_eisr_o   (rsp_eisr),
        .rsp_timeout_o(rsp_tmo)
    );

    always #5 clk = ~clk;

    // Slave model: acks after s_delay wait cycles, logs each completed access.
    logic        s_ack;
    logic [31:0] s_dat;
    int          s_wait;
    int          s_delay = 0;
    int          s_busy = 0;
    logic [31:0] s_resp = 32'd0;
    logic [15:0] s_nisr = 16'd0;
    logic [15:0] s_eisr = 16'd0;
    bit          s_hold = 1'b0;
    logic [7:0]  s_hold_adr = 8'h00;
    int          stat_total = 0;
    int          stat_base = 0;
    txn_t        log_a [0:1023];
    int          log_n = 0;
    int          log_base = 0;

    assign wb.wbm_ack_i = s_ack;
    assign wb.wbm_dat_i = s_dat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack  <= 1'b0;
            s_wait <= 0;
        end else begin
            s_ack <= 1'b0;
            if (wb.wbm_cyc_o && wb.wbm_stb_o && !s_ack &&
                !(s_hold && wb.wbm_adr_o == s_hold_adr)) begin
                if (s_wait >= s_delay) begin
                    s_ack  <= 1'b1;
                    s_wait <= 0;
                    if (log_n < 1024) log_a[log_n] <= {wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_dat_o};
                    log_n <= log_n + 1;
                    case (wb.wbm_adr_o)
                        8'h08: begin
                            s_dat <= {31'($urandom), ((stat_total - stat_base) < s_busy)};
                            stat_total <= stat_total + 1;
                        end
                        8'h0C:   s_dat <= s_resp;
                        8'h30:   s_dat <= {16'($urandom), s_nisr};
                        8'h34:   s_dat <= {16'($urandom), s_eisr};
                        default: s_dat <= $urandom;
                    endcase
                end else begin
                    s_wait <= s_wait + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        chk++;
        if (got !== want) begin
            err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Bus protocol monitor, sampled on the falling edge.
    task automatic monitor();
        logic p_stb, p_ack, p_we;
        logic [7:0] p_adr;
        logic [31:0] p_dat;
        bit p_ok;
        p_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_ok = 1'b0;
                continue;
            end
            if (wb.wbm_stb_o) check("stb_without_cyc", 32'(wb.wbm_cyc_o), 32'd1);
            if (p_ok && p_stb && !p_ack) begin
                check("held_until_ack",
                      32'(wb.wbm_stb_o && wb.wbm_cyc_o && wb.wbm_we_o == p_we &&
                          wb.wbm_adr_o == p_adr && wb.wbm_dat_o == p_dat), 32'd1);
            end
            if (p_ok && p_ack) check("idle_after_ack", 32'(wb.wbm_cyc_o), 32'd0);
            p_stb = wb.wbm_stb_o;
            p_ack = wb.wbm_ack_i;
            p_we  = wb.wbm_we_o;
            p_adr = wb.wbm_adr_o;
            p_dat = wb.wbm_dat_o;
            p_ok  = 1'b1;
        end
    endtask

    // Reference model: the access list and result a request must produce.
    txn_t        exp_q[$];
    logic [31:0] x_resp;
    logic [15:0] x_nisr, x_eisr;
    logic        x_tmo;
    logic [31:0] h_resp;
    logic [15:0] h_nisr, h_eisr;
    logic        h_tmo;

    task automatic build_expect(input logic [1:0] kind, input logic [15:0] cmd,
                                input logic [31:0] arg, input logic [31:0] arg2, input int busy,
                                input logic [31:0] resp, input logic [15:0] nisr,
                                input logic [15:0] eisr);
        logic [7:0] a;
        int nreads;
        exp_q.delete();
        if (kind == 2'd1 || kind == 2'd2) begin
            a = (kind == 2'd1) ? 8'h80 : 8'h60;
            exp_q.push_back({1'b1, a, arg});
            exp_q.push_back({1'b1, a, arg2});
            x_resp = 32'd0;
            x_nisr = 16'd0;
            x_eisr = 16'd0;
            x_tmo  = 1'b0;
        end else begin
            exp_q.push_back({1'b1, 8'h04, 16'h0000, cmd});
            exp_q.push_back({1'b1, 8'h00, arg});
            x_tmo  = (busy >= int'(PM));
            nreads = x_tmo ? int'(PM) : busy + 1;
            for (int i = 0; i < nreads; i++) exp_q.push_back({1'b0, 8'h08, 32'd0});
            if (!x_tmo) exp_q.push_back({1'b0, 8'h0C, 32'd0});
            exp_q.push_back({1'b0, 8'h30, 32'd0});
            exp_q.push_back({1'b0, 8'h34, 32'd0});
            if (nisr != 16'd0) exp_q.push_back({1'b1, 8'h30, 32'd0});
            if (eisr != 16'd0) exp_q.push_back({1'b1, 8'h34, 32'd0});
            x_resp = x_tmo ? 32'd0 : resp;
            x_nisr = nisr;
            x_eisr = eisr;
        end
    endtask

    task automatic compare_txns(input string tag);
        int n;
        n = log_n - log_base;
        check({tag, "_txn_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check({tag, "_txn_we"}, 32'(log_a[log_base + i].we), 32'(exp_q[i].we));
            check({tag, "_txn_adr"}, 32'(log_a[log_base + i].adr), 32'(exp_q[i].adr));
            if (exp_q[i].we) check({tag, "_txn_dat"}, log_a[log_base + i].dat, exp_q[i].dat);
        end
    endtask

    task automatic set_slave(input int busy, input int delay, input logic [31:0] resp,
                             input logic [15:0] nisr, input logic [15:0] eisr);
        s_busy  = busy;
        s_delay = delay;
        s_resp  = resp;
        s_nisr  = nisr;
        s_eisr  = eisr;
    endtask

    // Issue one request and wait (bounded) for its response; called on a falling edge.
    task automatic run_req(input string tag, input logic [1:0] kind, input logic [15:0] cmd,
                           input logic [31:0] arg, input logic [31:0] arg2, output bit ok);
        int n;
        ok = 1'b0;
        stat_base = stat_total;
        log_base  = log_n;
        req_kind  = kind;
        req_cmd   = cmd;
        req_arg   = arg;
        req_arg2  = arg2;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_ready_wait"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(req_ready), 32'd0);
        check({tag, "_hold_resp"}, rsp_resp, h_resp);
        check({tag, "_hold_tmo"}, 32'(rsp_tmo), 32'(h_tmo));
        n = 0;
        while (!rsp_valid && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            check({tag, "_rsp_wait"}, 32'(rsp_valid), 32'd1);
            return;
        end
        ok = 1'b1;
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] e_resp,
                             input logic [15:0] e_nisr, input logic [15:0] e_eisr,
                             input logic e_tmo);
        check({tag, "_resp"}, rsp_resp, e_resp);
        check({tag, "_nisr"}, 32'(rsp_nisr), 32'(e_nisr));
        check({tag, "_eisr"}, 32'(rsp_eisr), 32'(e_eisr));
        check({tag, "_tmo"}, 32'(rsp_tmo), 32'(e_tmo));
        check({tag, "_ready_in_done"}, 32'(req_ready), 32'd0);
        h_resp = e_resp;
        h_nisr = e_nisr;
        h_eisr = e_eisr;
        h_tmo  = e_tmo;
    endtask

    task automatic check_pulse_end(input string tag);
        @(negedge clk);
        check({tag, "_valid_one_cycle"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_after_done"}, 32'(req_ready), 32'd1);
    endtask

    vec_t vt[7];

    initial begin
        bit ok;
        bit seen;
        int n;
        string tag;
        logic [1:0]  k;
        logic [15:0] c;
        logic [31:0] a, a2;

        vt[0] = '{2'd0, 16'h0119, 32'h0000_0200, 32'h0, 3, 0, 32'h0000_0900, 16'h0001, 16'h0000,
                  10, 32'h0000_0900, 16'h0001, 16'h0000, 1'b0, 8'h30};
        vt[1] = '{2'd1, 16'h0000, 32'h1000_0000, 32'h0000_0040, 0, 2, 32'hDEAD, 16'h5, 16'h5,
                  2, 32'h0, 16'h0, 16'h0, 1'b0, 8'h80};
        vt[2] = '{2'd0, 16'h000D, 32'h0000_0001, 32'h0, 99, 1, 32'h0000_0777, 16'h0002, 16'h0000,
                  10, 32'h0, 16'h0002, 16'h0000, 1'b1, 8'h30};
        vt[3] = '{2'd0, 16'h000C, 32'h0, 32'h0, 0, 0, 32'h1234_5678, 16'h8000, 16'h0004,
                  8, 32'h1234_5678, 16'h8000, 16'h0004, 1'b0, 8'h34};
        vt[4] = '{2'd2, 16'h0000, 32'hABCD_0000, 32'h0000_1111, 0, 1, 32'h1, 16'h1, 16'h1,
                  2, 32'h0, 16'h0, 16'h0, 1'b0, 8'h60};
        vt[5] = '{2'd3, 16'h1234, 32'h0000_0005, 32'h0, 0, 0, 32'h0000_0055, 16'h0, 16'h0,
                  6, 32'h0000_0055, 16'h0, 16'h0, 1'b0, 8'h34};
        vt[6] = '{2'd0, 16'h0011, 32'h0000_0009, 32'h0, 4, 3, 32'h0000_00AA, 16'h0, 16'h0,
                  10, 32'h0000_00AA, 16'h0, 16'h0, 1'b0, 8'h34};

        fork
            monitor();
        join_none

        // Reset state
        #12;
        check("rst_cyc", 32'(wb.wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(wb.wbm_stb_o), 32'd0);
        check("rst_we", 32'(wb.wbm_we_o), 32'd0);
        check("rst_adr", 32'(wb.wbm_adr_o), 32'd0);
        check("rst_dat", wb.wbm_dat_o, 32'd0);
        check("rst_sel", 32'(wb.wbm_sel_o), 32'hF);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_resp", rsp_resp, 32'd0);
        check("rst_rsp_isr", {rsp_nisr, rsp_eisr}, 32'd0);
        check("rst_rsp_tmo", 32'(rsp_tmo), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        h_resp = 32'd0;
        h_nisr = 16'd0;
        h_eisr = 16'd0;
        h_tmo  = 1'b0;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("vec%0d", i);
            set_slave(vt[i].busy, vt[i].delay, vt[i].resp, vt[i].nisr, vt[i].eisr);
            build_expect(vt[i].kind, vt[i].cmd, vt[i].arg, vt[i].arg2, vt[i].busy,
                         vt[i].resp, vt[i].nisr, vt[i].eisr);
            run_req(tag, vt[i].kind, vt[i].cmd, vt[i].arg, vt[i].arg2, ok);
            if (ok) begin
                check({tag, "_n"}, 32'(log_n - log_base), 32'(vt[i].exp_n));
                check({tag, "_last_adr"}, 32'(log_a[log_n - 1].adr), 32'(vt[i].exp_last));
                compare_txns(tag);
                check_rsp(tag, vt[i].exp_resp, vt[i].exp_nisr, vt[i].exp_eisr, vt[i].exp_tmo);
                check_pulse_end(tag);
            end
        end

        // Randomized requests against the model
        for (int i = 0; i < 24; i++) begin
            tag = $sformatf("rnd%0d", i);
            k  = 2'($urandom_range(0, 3));
            c  = 16'($urandom);
            a  = $urandom;
            a2 = $urandom;
            set_slave(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), $urandom,
                      ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0,
                      ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0);
            build_expect(k, c, a, a2, s_busy, s_resp, s_nisr, s_eisr);
            run_req(tag, k, c, a, a2, ok);
            if (ok) begin
                compare_txns(tag);
                check_rsp(tag, x_resp, x_nisr, x_eisr, x_tmo);
                check_pulse_end(tag);
            end
        end

        // Back-to-back with req_valid held: second accept only after the response cycle
        set_slave(1, 1, 32'h0000_4321, 16'h0010, 16'h0000);
        build_expect(2'd0, 16'h0033, 32'h0000_0077, 32'h0, 1, 32'h0000_4321, 16'h0010, 16'h0);
        run_req("b2b_a", 2'd0, 16'h0033, 32'h0000_0077, 32'h0, ok);
        if (ok) begin
            req_valid = 1'b1;
            req_kind  = 2'd1;
            req_arg   = 32'h2000_0000;
            req_arg2  = 32'h0000_0080;
            compare_txns("b2b_a");
            check_rsp("b2b_a", x_resp, x_nisr, x_eisr, x_tmo);
            log_base = log_n;
            @(negedge clk);
            check("b2b_ready_after_done", 32'(req_ready), 32'd1);
            @(negedge clk);
            check("b2b_second_accepted", 32'(req_ready), 32'd0);
            req_valid = 1'b0;
            build_expect(2'd1, 16'h0, 32'h2000_0000, 32'h0000_0080, 0, 32'h0, 16'h0, 16'h0);
            n = 0;
            while (!rsp_valid && n < 4000) begin
                @(negedge clk);
                n++;
            end
            check("b2b_b_rsp_seen", 32'(rsp_valid), 32'd1);
            if (rsp_valid) begin
                compare_txns("b2b_b");
                check_rsp("b2b_b", 32'h0, 16'h0, 16'h0, 1'b0);
                check_pulse_end("b2b_b");
            end
        end

        // Reset while the argument write waits for an ack that never comes
        s_hold_adr = 8'h00;
        s_hold     = 1'b1;
        set_slave(0, 0, 32'h0, 16'h0, 16'h0);
        req_kind  = 2'd0;
        req_cmd   = 16'h0007;
        req_arg   = 32'h0000_0123;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(wb.wbm_cyc_o && wb.wbm_adr_o == 8'h00) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_reached_wr_arg", 32'(wb.wbm_cyc_o && wb.wbm_adr_o == 8'h00), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", 32'(wb.wbm_cyc_o), 32'd0);
        check("mid_rst_stb", 32'(wb.wbm_stb_o), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        s_hold = 1'b0;
        h_resp = 32'd0;
        h_nisr = 16'd0;
        h_eisr = 16'd0;
        h_tmo  = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (wb.wbm_cyc_o || wb.wbm_stb_o || rsp_valid) seen = 1'b1;
        end
        check("mid_rst_bus_quiet", 32'(seen), 32'd0);

        // Recovery after reset
        set_slave(0, 0, 32'h0, 16'h0, 16'h0);
        build_expect(2'd2, 16'h0, 32'h3000_0000, 32'h0000_0002, 0, 32'h0, 16'h0, 16'h0);
        run_req("post_rst", 2'd2, 16'h0, 32'h3000_0000, 32'h0000_0002, ok);
        if (ok) begin
            compare_txns("post_rst");
            check_rsp("post_rst", 32'h0, 16'h0, 16'h0, 1'b0);
            check_pulse_end("post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule

// File: doc/sd_wb_cmd_master.md
SD_WB_CMD_MASTER -- requirements
Module: sd_wb_cmd_master

Interface
- REQ-001 SHALL have parameter POLL_MAX, default 16'd1000, meaning the maximum number of status reads per command before timeout.
- REQ-002 SHALL have parameter POLL_GAP, default 8'd4, meaning idle cycles between consecutive status reads.
- REQ-003 SHALL use one clock and an asynchronous, active-low reset.
- REQ-004 wb_clk_i  in  1  Wishbone clock; all logic on rising edge.
- REQ-005 wb_rst_n_i  in  1  asynchronous active-low reset.
- REQ-006 req_valid_i  in  1  request present.
- REQ-007 req_ready_o  out  1  block idle; request accepted when valid & ready.
- REQ-008 req_kind_i  in  2  0=CMD, 1=BD_TX, 2=BD_RX; 3 is treated as CMD.
- REQ-009 req_cmd_i  in  16  command setting word; CMD only.
- REQ-010 req_arg_i  in  32  argument (CMD), or first BD word (buffer address).
- REQ-011 req_arg2_i  in  32  second BD word (card block address); BD only.
- REQ-012 wbm_adr_o/wbm_dat_o/wbm_sel_o  out  8/32/4  Wishbone address, write data, byte select (sel always 4'hF).
- REQ-013 wbm_we_o/wbm_cyc_o/wbm_stb_o  out  1 each  Wishbone controls.
- REQ-014 wbm_dat_i/wbm_ack_i  in  32/1  read data and acknowledge.
- REQ-015 rsp_valid_o  out  1  one-cycle completion pulse.
- REQ-016 rsp_resp_o/rsp_nisr_o/rsp_eisr_o  out  32/16/16  captured resp1, normal ISR, and error ISR.
- REQ-017 rsp_timeout_o  out  1  poll limit exceeded; qualified by rsp_valid_o.

Function
- REQ-018 Register map: argument 0x00, command 0x04, status 0x08, resp1 0x0C, normal_isr 0x30, error_isr 0x34, bd_rx 0x60, bd_tx 0x80.
- REQ-019 Every bus access is a single transfer.
  - cyc/stb/we/adr/dat are held stable from assertion until the cycle wbm_ack_i=1.
  - cyc and stb are deasserted the following cycle.
  - The bus stays idle for at least one cycle between accesses.
  - Ack latency is unbounded, so the multi-cycle BD ack stretch is tolerated.
- REQ-020 Read data is captured on the ack cycle.
- REQ-021 FSM states: IDLE, WR_CMD, WR_ARG, POLL_RD, POLL_WAIT, RD_RESP, RD_NISR, RD_EISR, CLR_NISR, CLR_EISR, BD_W0, BD_W1, DONE.
- REQ-022 In IDLE, req_ready_o=1. On accept, all request fields are latched.
  - CMD goes to WR_CMD.
  - BD_TX/BD_RX goes to BD_W0.
- REQ-023 CMD sequence:
  - WR_CMD writes {16'h0, cmd} to 0x04, then WR_ARG writes arg to 0x00.
  - The command word is always written before the argument.
- REQ-024 Polling:
  - POLL_RD reads 0x08.
  - If status[0]=1 and the poll count is below POLL_MAX, go to POLL_WAIT for POLL_GAP cycles, then back to POLL_RD.
  - If status[0]=0, go to RD_RESP.
- REQ-025 A 16-bit poll counter is cleared on accept and incremented on each status ack.
  - If it reaches POLL_MAX with status[0] still 1, set the timeout flag and skip RD_RESP; rsp_resp_o = 0.
- REQ-026 After the response: RD_NISR reads 0x30, then RD_EISR reads 0x34.
  - CLR_NISR writes 0 to 0x30 only if nisr≠0.
  - CLR_EISR writes 0 to 0x34 only if eisr≠0.
  - Then DONE.
- REQ-027 BD sequence:
  - BD_W0 writes arg and BD_W1 writes arg2, to 0x80 (TX) or 0x60 (RX).
  - Then DONE, with rsp_* data = 0 and timeout = 0.
- REQ-028 DONE asserts rsp_valid_o for exactly one cycle, then returns to IDLE.
  - req_ready_o rises in the cycle after DONE.
  - rsp_* data outputs hold their values until the next DONE.
- REQ-029 A request arriving while busy is not accepted and there is no queueing; req_valid_i must be held by the source.
- REQ-030 Poll-gap counter arithmetic: 8-bit down-counter. POLL_GAP=0 means the next read is issued after the mandatory idle cycle.

Reset
- REQ-031 Asynchronous reset SHALL force: state IDLE; wbm_cyc_o=wbm_stb_o=wbm_we_o=0; wbm_adr_o=0; wbm_dat_o=0; wbm_sel_o=4'hF; rsp_valid_o=0; rsp_resp_o/rsp_nisr_o/rsp_eisr_o=0; rsp_timeout_o=0; all counters 0; req_ready_o=1 after release.
- REQ-032 Reset asserted mid-transfer SHALL drop cyc/stb in the same cycle. Nothing is resumed after release.

Verification
- REQ-033 CMD, cmd=16'h0119, arg=32'h0000_0200; slave shows status[0]=1 for 3 reads, then 0; resp1=32'h0000_0900, nisr=16'h0001, eisr=0 -> writes 0x04=0x0119 then 0x00=0x200; 4 status reads; clear write to 0x30 only; rsp_valid pulse with rsp_resp=0x900, nisr=1, timeout=0.
- REQ-034 BD_TX, arg=32'h1000_0000, arg2=32'h0000_0040; slave delays ack 2 cycles -> exactly two writes to 0x80 in that order, stb held until each ack, a ≥1 idle cycle between them, rsp_valid with data 0.
- REQ-035 POLL_MAX=5, status stuck at 1 -> exactly 5 status reads; no 0x0C read; 0x30 and 0x34 still read; rsp_timeout=1, rsp_resp=0.
- REQ-036 eisr=16'h0004, nisr=16'h8000 -> clear writes to both 0x30 and 0x34; rsp_eisr=4.
- REQ-037 Reset pulse during WR_ARG with ack withheld -> cyc/stb=0 immediately, ready=1 after release, no further bus activity until a new request.
- REQ-038 req_valid held high across back-to-back requests -> second request accepted only in the cycle after rsp_valid; a Wishbone protocol checker reports no stb-without-cyc and no changes while stb is awaiting ack.
